// File: rtl/fir_filter_mc.sv
// Time-multiplexed multi-channel FIR: one shared MAC,
// per-channel circular delay lines, writable coefficient bank.
module fir_filter_mc #(
  parameter int NUM_TAPS       = 51,
  parameter int CHANNELS       = 2,
  parameter int CH_WIDTH       = 1,
  parameter int DATA_IN_WIDTH  = 16,
  parameter int COEF_WIDTH     = 16,
  parameter int TAP_ADDR_WIDTH = 6,
  parameter int ACC_WIDTH      = 40,
  parameter int OUT_SHIFT      = 14,
  parameter int DATA_OUT_WIDTH = 16
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_in_valid,
  output logic                      o_in_ready,
  input  logic [DATA_IN_WIDTH-1:0]  i_in_data,
  input  logic [CH_WIDTH-1:0]       i_in_ch,
  output logic                      o_out_valid,
  output logic [DATA_OUT_WIDTH-1:0] o_out_data,
  output logic [CH_WIDTH-1:0]       o_out_ch,
  output logic                      o_sat,
  input  logic                      i_coef_wr_en,
  input  logic [TAP_ADDR_WIDTH-1:0] i_coef_wr_addr,
  input  logic [COEF_WIDTH-1:0]     i_coef_wr_data,
  output logic                      o_coef_wr_err,
  input  logic                      i_clear,
  output logic                      o_busy
);

  localparam int AW = TAP_ADDR_WIDTH;
  localparam int PW = DATA_IN_WIDTH + COEF_WIDTH;
  localparam logic [AW-1:0] LAST = AW'(NUM_TAPS - 1);
  localparam logic [AW:0] KEND = (AW+1)'(NUM_TAPS);
  localparam logic signed [ACC_WIDTH-1:0] RND =
    ACC_WIDTH'(1) << (OUT_SHIFT - 1);
  localparam logic signed [ACC_WIDTH-1:0] OMAX =
    (ACC_WIDTH'(1) << (DATA_OUT_WIDTH - 1)) - ACC_WIDTH'(1);
  localparam logic signed [ACC_WIDTH-1:0] OMIN = ~OMAX;
  localparam logic signed [COEF_WIDTH-1:0] UNITY =
    COEF_WIDTH'(1) << OUT_SHIFT;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MAC,
    S_OUT
  } state_t;

  state_t state;

  logic signed [DATA_IN_WIDTH-1:0] dline [CHANNELS][NUM_TAPS];
  logic [AW-1:0]                   wptr  [CHANNELS];
  logic signed [COEF_WIDTH-1:0]    coef  [NUM_TAPS];

  logic [AW-1:0]                 rptr;
  logic [AW:0]                   k;
  logic [CH_WIDTH-1:0]           ch_q;
  logic signed [PW-1:0]          prod;
  logic signed [PW-1:0]          c_ext;
  logic signed [PW-1:0]          x_ext;
  logic                          prod_v;
  logic signed [ACC_WIDTH-1:0]   acc;
  logic signed [ACC_WIDTH-1:0]   rnd;
  logic signed [ACC_WIDTH-1:0]   shf;
  logic signed [DATA_OUT_WIDTH-1:0] res;
  logic idle;
  logic ch_ok;
  logic wr_ok;
  logic accept;
  logic hi;
  logic lo;

  assign idle       = (state == S_IDLE);
  assign o_in_ready = idle && !i_clear;
  assign o_busy     = !idle;
  assign accept     = i_in_valid && o_in_ready;
  assign ch_ok      = int'(i_in_ch) < CHANNELS;
  assign wr_ok      = idle && (int'(i_coef_wr_addr) < NUM_TAPS);

  assign c_ext = PW'(coef[k[AW-1:0]]);
  assign x_ext = PW'(dline[ch_q][rptr]);

  assign rnd = acc + RND;
  assign shf = rnd >>> OUT_SHIFT;
  assign hi  = shf > OMAX;
  assign lo  = shf < OMIN;

  always_comb begin
    res = shf[DATA_OUT_WIDTH-1:0];
    unique case (1'b1)
      hi:      res = OMAX[DATA_OUT_WIDTH-1:0];
      lo:      res = OMIN[DATA_OUT_WIDTH-1:0];
      default: ;
    endcase
  end

  // Multiply is registered, so MAC runs one
  // extra cycle to drain the last product.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= S_IDLE;
      rptr          <= '0;
      k             <= '0;
      ch_q          <= '0;
      prod          <= '0;
      prod_v        <= 1'b0;
      acc           <= '0;
      o_out_valid   <= 1'b0;
      o_out_data    <= '0;
      o_out_ch      <= '0;
      o_sat         <= 1'b0;
      o_coef_wr_err <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        wptr[c] <= '0;
        for (int t = 0; t < NUM_TAPS; t++)
          dline[c][t] <= '0;
      end
      for (int t = 0; t < NUM_TAPS; t++)
        coef[t] <= (t == 0) ? UNITY : '0;
    end else begin
      o_out_valid   <= 1'b0;
      o_coef_wr_err <= 1'b0;

      if (i_coef_wr_en) begin
        if (wr_ok)
          coef[i_coef_wr_addr] <= i_coef_wr_data;
        else
          o_coef_wr_err <= 1'b1;
      end

      unique case (state)
        S_IDLE: begin
          if (i_clear) begin
            for (int c = 0; c < CHANNELS; c++) begin
              wptr[c] <= '0;
              for (int t = 0; t < NUM_TAPS; t++)
                dline[c][t] <= '0;
            end
          end else if (accept && ch_ok) begin
            dline[i_in_ch][wptr[i_in_ch]] <= i_in_data;
            wptr[i_in_ch] <= (wptr[i_in_ch] == LAST)
                           ? '0 : wptr[i_in_ch] + AW'(1);
            rptr   <= wptr[i_in_ch];
            ch_q   <= i_in_ch;
            k      <= '0;
            acc    <= '0;
            prod_v <= 1'b0;
            state  <= S_MAC;
          end
        end
        S_MAC: begin
          if (k != KEND) begin
            prod <= c_ext * x_ext;
            rptr <= (rptr == '0) ? LAST : rptr - AW'(1);
          end
          prod_v <= (k != KEND);
          if (prod_v)
            acc <= acc + ACC_WIDTH'(prod);
          if (k == KEND)
            state <= S_OUT;
          k <= k + (AW+1)'(1);
        end
        S_OUT: begin
          o_out_data  <= res;
          o_sat       <= hi | lo;
          o_out_ch    <= ch_q;
          o_out_valid <= 1'b1;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_filter_mc.sv
// Bench for fir_filter_mc: queue-based FIR model,
// per-cycle output compare, literal pins.
module tb_fir_filter_mc;

  localparam int N   = 51;
  localparam int LAT = N + 2;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_in_valid = 1'b0;
  logic        o_in_ready;
  logic [15:0] i_in_data = '0;
  logic [0:0]  i_in_ch = '0;
  logic        o_out_valid;
  logic [15:0] o_out_data;
  logic [0:0]  o_out_ch;
  logic        o_sat;
  logic        i_coef_wr_en = 1'b0;
  logic [5:0]  i_coef_wr_addr = '0;
  logic [15:0] i_coef_wr_data = '0;
  logic        o_coef_wr_err;
  logic        i_clear = 1'b0;
  logic        o_busy;

  fir_filter_mc dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_in_valid     (i_in_valid),
    .o_in_ready     (o_in_ready),
    .i_in_data      (i_in_data),
    .i_in_ch        (i_in_ch),
    .o_out_valid    (o_out_valid),
    .o_out_data     (o_out_data),
    .o_out_ch       (o_out_ch),
    .o_sat          (o_sat),
    .i_coef_wr_en   (i_coef_wr_en),
    .i_coef_wr_addr (i_coef_wr_addr),
    .i_coef_wr_data (i_coef_wr_data),
    .o_coef_wr_err  (o_coef_wr_err),
    .i_clear        (i_clear),
    .o_busy         (o_busy)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  typedef struct {
    int data;
    int ch;
    int sat;
    int due;
  } exp_t;

  exp_t ex [512];
  int   wi = 0;
  int   ri = 0;
  int   mc [N];
  int   hist [2][$];
  int   obs_d [$];
  int   obs_s [$];
  int   obs_t [$];
  int   last_acc = 0;
  int   checks = 0;
  int   passes = 0;
  bit   done = 1'b0;

  task automatic chk(input string nm,
                     input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0d, want %0d", nm, act, exp);
  endtask

  function automatic void model_reset();
    for (int t = 0; t < N; t++) mc[t] = 0;
    mc[0] = 16384;
    hist[0].delete();
    hist[1].delete();
  endfunction

  // Direct convolution over the newest-first history.
  function automatic void model_accept(int ch, int d);
    longint s = 0;
    longint r;
    int sat = 0;
    hist[ch].push_front(d);
    if (hist[ch].size() > N) void'(hist[ch].pop_back());
    for (int t = 0; t < hist[ch].size(); t++)
      s += longint'(mc[t]) * longint'(hist[ch][t]);
    r = (s + 8192) >>> 14;
    if (r > 32767) begin r = 32767; sat = 1; end
    else if (r < -32768) begin r = -32768; sat = 1; end
    last_acc = cyc;
    ex[wi] = '{int'(r), ch, sat, cyc + LAT};
    wi++;
  endfunction

  task automatic send(input int ch, input int d);
    int n = 0;
    @(negedge i_clk);
    while (!o_in_ready && n < 300) begin
      @(negedge i_clk);
      n++;
    end
    if (n >= 300) chk("ready_timeout", o_in_ready, 1);
    i_in_valid = 1'b1;
    i_in_data  = 16'(d);
    i_in_ch    = 1'(ch);
    @(posedge i_clk);
    #1;
    i_in_valid = 1'b0;
    model_accept(ch, d);
  endtask

  task automatic wcoef(input int a, input int v, input int exp_err);
    @(negedge i_clk);
    i_coef_wr_en   = 1'b1;
    i_coef_wr_addr = 6'(a);
    i_coef_wr_data = 16'(v);
    @(posedge i_clk);
    #1;
    i_coef_wr_en = 1'b0;
    chk("coef_wr_err", o_coef_wr_err, exp_err);
    if (exp_err != 0) begin
      @(posedge i_clk);
      #1;
      chk("coef_wr_err_end", o_coef_wr_err, 0);
    end else begin
      mc[a] = v;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (ri < wi && n < 300) begin
      @(negedge i_clk);
      #1;
      n++;
    end
    if (ri != wi) chk("drain_timeout", ri, wi);
  endtask

  initial begin
    int b;
    model_reset();
    fork
      begin
        while (!done) begin
          @(negedge i_clk);
          if (i_rst_n) begin
            while (ri < wi && ex[ri].due < 0) ri++;
            if (o_out_valid) begin
              obs_d.push_back(int'($signed(o_out_data)));
              obs_s.push_back(int'(o_sat));
              obs_t.push_back(cyc);
              if (ri < wi && ex[ri].due == cyc) begin
                chk("out_data", $signed(o_out_data), ex[ri].data);
                chk("out_ch", o_out_ch, ex[ri].ch);
                chk("out_sat", o_sat, ex[ri].sat);
                ri++;
              end else begin
                chk("unexpected_valid", o_out_valid, 0);
              end
            end else if (ri < wi && ex[ri].due == cyc) begin
              chk("missing_valid", o_out_valid, 1);
              ri++;
            end
          end
        end
      end
      begin
        #1;
        chk("rst_ready", o_in_ready, 1);
        chk("rst_valid", o_out_valid, 0);
        chk("rst_data", o_out_data, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_err", o_coef_wr_err, 0);
        repeat (3) @(negedge i_clk);
        i_rst_n = 1'b1;

        b = obs_d.size();
        send(0, 1234);
        drain();
        chk("t1_data", obs_d[b], 1234);
        chk("t1_sat", obs_s[b], 0);
        chk("t1_latency", obs_t[b] - last_acc, 53);

        for (int a = 0; a < N; a++)
          wcoef(a, (a < 4) ? 4096 : 0, 0);
        model_reset();
        for (int t = 0; t < 4; t++) mc[t] = 4096;
        i_clear = 1'b1;
        @(posedge i_clk);
        #1;
        i_clear = 1'b0;
        b = obs_d.size();
        send(0, 1000);
        send(1, -2000);
        send(0, 1000);
        send(1, -2000);
        send(0, 1000);
        send(0, 1000);
        send(0, 1000);
        drain();
        chk("t2_o0", obs_d[b], 250);
        chk("t2_o1", obs_d[b+1], -500);
        chk("t2_o2", obs_d[b+2], 500);
        chk("t2_o3", obs_d[b+3], -1000);
        chk("t2_o4", obs_d[b+4], 750);
        chk("t2_o6", obs_d[b+6], 1000);

        send(0, 1000);
        drain();
        @(negedge i_clk);
        i_clear    = 1'b1;
        i_in_valid = 1'b1;
        i_in_data  = 16'd999;
        #1;
        chk("clear_ready", o_in_ready, 0);
        @(posedge i_clk);
        #1;
        i_clear    = 1'b0;
        i_in_valid = 1'b0;
        hist[0].delete();
        hist[1].delete();
        b = obs_d.size();
        send(0, 1000);
        drain();
        chk("t5_after_clear", obs_d[b], 250);

        wcoef(0, 32767, 0);
        wcoef(1, 32767, 0);
        wcoef(2, 0, 0);
        wcoef(3, 0, 0);
        b = obs_d.size();
        send(0, 32767);
        send(0, 32767);
        send(0, -32767);
        send(0, -32767);
        drain();
        chk("t3_pos", obs_d[b+1], 32767);
        chk("t3_pos_sat", obs_s[b+1], 1);
        chk("t3_zero", obs_d[b+2], 0);
        chk("t3_neg", obs_d[b+3], -32768);
        chk("t3_neg_sat", obs_s[b+3], 1);

        b = obs_d.size();
        send(1, 1);
        chk("t4_busy", o_busy, 1);
        wcoef(0, 0, 1);
        drain();
        wcoef(51, 123, 1);
        send(1, 2);
        drain();
        chk("t4_o0", obs_d[b], 2);
        chk("t4_o1", obs_d[b+1], 6);

        send(0, 500);
        repeat (10) @(negedge i_clk);
        ex[wi-1].due = -1;
        i_rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", o_in_ready, 1);
        chk("mid_rst_busy", o_busy, 0);
        chk("mid_rst_valid", o_out_valid, 0);
        chk("mid_rst_data", o_out_data, 0);
        chk("mid_rst_sat", o_sat, 0);
        repeat (3) @(negedge i_clk);
        i_rst_n = 1'b1;
        model_reset();
        repeat (60) @(negedge i_clk);
        b = obs_d.size();
        send(0, 77);
        drain();
        chk("t6_identity", obs_d[b], 77);
        repeat (2) @(negedge i_clk);
        done = 1'b1;
      end
    join
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
